// File: rtl/ledr_pio_arbiter_pkg.sv
// ledr_pio_arbiter_pkg: FSM state encoding and parameter defaults shared by the
// arbiter top and its round-robin selector.
package ledr_pio_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam int NUM_REQ_DEF = 3;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 2;
endpackage

// File: rtl/ledr_pio_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick; priority starts one past last_grant.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    logic [IW-1:0] pos;
    // Scan from lowest to highest priority so the nearest requester overwrites.
    always_comb begin
        grant = '0;
        index = '0;
        pos = '0;
        for (int k = N; k >= 1; k--) begin
            pos = IW'((int'(last_grant) + k) % N);
            if (req[pos]) begin
                grant = '0;
                grant[pos] = 1'b1;
                index = pos;
            end
        end
    end
endmodule

// File: rtl/ledr_pio_arbiter.sv
// ledr_pio_arbiter: shares one zero-wait Avalon-MM PIO slave among NUM_REQ
// requesters, one three-cycle transaction (accept, access, response) at a time.
module ledr_pio_arbiter
    import ledr_pio_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [ADDR_W-1:0]           pio_address,
    output logic                        pio_chipselect,
    output logic                        pio_write_n,
    output logic [DATA_W-1:0]           pio_writedata,
    input  logic [DATA_W-1:0]           pio_readdata
);
    localparam int IW = $clog2(NUM_REQ);

    state_t state, state_next;
    logic [IW-1:0] last_grant, win_idx, arb_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic op, accept;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r, rdata_r;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req(req_valid),
        .last_grant(last_grant),
        .grant(arb_grant),
        .index(arb_idx)
    );

    assign req_ready = (state == IDLE && !reset) ? arb_grant : '0;
    assign accept = |req_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            win_idx <= '0;
            op <= 1'b0;
            addr_r <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= arb_idx;
                win_idx <= arb_idx;
                op <= req_write[arb_idx];
                addr_r <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                wdata_r <= req_wdata[arb_idx*DATA_W +: DATA_W];
            end
            if (state == ACCESS)
                rdata_r <= op ? '0 : pio_readdata;
        end
    end

    assign pio_chipselect = state == ACCESS;
    assign pio_write_n = !(pio_chipselect && op);
    assign pio_address = pio_chipselect ? addr_r : '0;
    assign pio_writedata = pio_chipselect ? wdata_r : '0;
    assign rsp_valid = (state == RESP) ? NUM_REQ'(1) << win_idx : '0;
    assign rsp_rdata = (state == RESP) ? rdata_r : '0;
endmodule

// File: tb/tb_ledr_pio_arbiter.sv
// tb_ledr_pio_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic against a transaction-timeline reference model.
module tb_ledr_pio_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic [2:0] req_valid, req_write, req_ready, rsp_valid;
    logic [5:0] req_addr;
    logic [95:0] req_wdata;
    logic [31:0] rsp_rdata, pio_writedata, pio_readdata;
    logic [1:0] pio_address;
    logic pio_chipselect, pio_write_n;
    logic [31:0] pio_mem [4];
    logic [31:0] ref_mem [4];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ledr_pio_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata)
    );

    // Zero-wait PIO slave model
    assign pio_readdata = pio_chipselect ? pio_mem[pio_address] : 32'h0;
    always @(posedge clk)
        if (pio_chipselect && !pio_write_n) pio_mem[pio_address] <= pio_writedata;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] w, input logic [1:0] a, input logic [31:0] d);
        req_valid = v;
        req_write = w;
        req_addr = {3{a}};
        req_wdata = {3{d}};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(3'b000, 3'b000, 2'd0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [2:0] rr_pick(input logic [2:0] v, input int last);
        for (int k = 1; k <= 3; k++)
            if (v[(last + k) % 3]) return 3'(1 << ((last + k) % 3));
        return 3'b000;
    endfunction

    typedef struct {
        logic [2:0] v;
        logic [2:0] w;
        logic [1:0] a;
        logic [31:0] d;
        logic [2:0] ready;
        logic [31:0] rdata;
    } vec_t;
    vec_t tbl [6];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gidx [9];
        int gcyc [9];
        int ng;
        int t_acc, t_idx, ref_last;
        logic t_wr;
        logic [1:0] t_addr;
        logic [31:0] t_wd, t_rd;
        logic [2:0] e_ready, e_rsp;
        logic e_cs;
        for (int i = 0; i < 4; i++) pio_mem[i] = 32'h0;
        tbl[0] = '{3'b001, 3'b111, 2'd0, 32'h2A5,   3'b001, 32'h0};
        tbl[1] = '{3'b010, 3'b000, 2'd0, 32'h0,     3'b010, 32'h2A5};
        tbl[2] = '{3'b101, 3'b111, 2'd3, 32'h55,    3'b100, 32'h0};
        tbl[3] = '{3'b101, 3'b000, 2'd3, 32'h0,     3'b001, 32'h55};
        tbl[4] = '{3'b111, 3'b010, 2'd1, 32'h1234,  3'b010, 32'h0};
        tbl[5] = '{3'b011, 3'b000, 2'd1, 32'h0,     3'b001, 32'h1234};

        reset = 1'b1;
        drive(3'b111, 3'b111, 2'd1, 32'hFFFF);
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", req_ready, 3'b000);
        check("reset_rsp", rsp_valid, 3'b000);
        check("reset_cs", pio_chipselect, 1'b0);
        check("reset_wn", pio_write_n, 1'b1);
        check("reset_bus", {pio_address, pio_writedata}, 34'h0);
        @(negedge clk);
        drive(3'b000, 3'b000, 2'd0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, tbl[i].ready);
            @(negedge clk);
            drive(3'b000, 3'b000, 2'd0, 32'h0);
            #1;
            check($sformatf("vec%0d_cs", i), pio_chipselect, 1'b1);
            check($sformatf("vec%0d_wn", i), pio_write_n, ~|(tbl[i].w & tbl[i].ready));
            check($sformatf("vec%0d_bus", i), {pio_address, pio_writedata}, {tbl[i].a, tbl[i].d});
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_rsp", i), rsp_valid, tbl[i].ready);
            check($sformatf("vec%0d_rdata", i), rsp_rdata, tbl[i].rdata);
            check($sformatf("vec%0d_cs_off", i), pio_chipselect, 1'b0);
            @(negedge clk);
        end

        // Fairness with all requesters held active
        do_reset();
        drive(3'b111, 3'b000, 2'd2, 32'h0);
        ng = 0;
        for (int c = 0; c < 40 && ng < 9; c++) begin
            #1;
            if (|req_ready) begin
                for (int j = 0; j < 3; j++) if (req_ready[j]) gidx[ng] = j;
                gcyc[ng] = c;
                ng++;
            end
            @(negedge clk);
        end
        check("fair_count", ng, 9);
        for (int g = 0; g < ng; g++) begin
            check($sformatf("fair_order%0d", g), gidx[g], g % 3);
            if (g > 0) check($sformatf("fair_gap%0d", g), gcyc[g] - gcyc[g-1], 3);
        end
        drive(3'b000, 3'b000, 2'd0, 32'h0);
        repeat (3) @(negedge clk);

        // Reset asserted during ACCESS
        do_reset();
        drive(3'b100, 3'b100, 2'd2, 32'hDEAD);
        #1;
        check("abort_ready", req_ready, 3'b100);
        @(negedge clk);
        drive(3'b000, 3'b000, 2'd0, 32'h0);
        #1;
        check("abort_pre_cs", pio_chipselect, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_cs", pio_chipselect, 1'b0);
        check("abort_wn", pio_write_n, 1'b1);
        @(negedge clk);
        check("abort_rsp_t2", rsp_valid, 3'b000);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("abort_quiet", {rsp_valid, pio_chipselect}, 4'b0);
            @(negedge clk);
        end
        check("abort_mem", pio_mem[2], 32'h0);
        drive(3'b110, 3'b000, 2'd0, 32'h0);
        #1;
        check("abort_next_grant", req_ready, 3'b010);
        @(negedge clk);
        drive(3'b000, 3'b000, 2'd0, 32'h0);
        repeat (2) @(negedge clk);

        // Cancel: one-cycle request while busy is never granted
        drive(3'b001, 3'b000, 2'd0, 32'h0);
        #1;
        check("cancel_first", req_ready, 3'b001);
        @(negedge clk);
        drive(3'b000, 3'b000, 2'd0, 32'h0);
        @(negedge clk);
        drive(3'b010, 3'b010, 2'd3, 32'hBAD);
        #1;
        check("cancel_in_resp", req_ready, 3'b000);
        @(negedge clk);
        drive(3'b000, 3'b000, 2'd0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("cancel_quiet", {req_ready, pio_chipselect, rsp_valid}, 7'b0);
            @(negedge clk);
        end

        // Randomized traffic against the timeline model
        do_reset();
        for (int i = 0; i < 4; i++) ref_mem[i] = pio_mem[i];
        ref_last = 2;
        t_acc = -10;
        t_idx = 0; t_wr = 1'b0; t_addr = 2'd0; t_wd = 32'h0; t_rd = 32'h0;
        for (int c = 0; c < 300; c++) begin
            req_valid = 3'($urandom_range(0, 7));
            req_write = 3'($urandom_range(0, 7));
            req_addr = 6'($urandom);
            req_wdata = {$urandom, $urandom, $urandom};
            #1;
            e_cs = c == t_acc + 1;
            if (e_cs) begin
                if (t_wr) ref_mem[t_addr] = t_wd;
                else t_rd = ref_mem[t_addr];
            end
            e_rsp = (c == t_acc + 2) ? 3'(1 << t_idx) : 3'b000;
            e_ready = (c >= t_acc + 3) ? rr_pick(req_valid, ref_last) : 3'b000;
            check("rand_outputs",
                  {req_ready, pio_chipselect, pio_write_n, pio_address, pio_writedata, rsp_valid},
                  {e_ready, e_cs, !(e_cs && t_wr), e_cs ? t_addr : 2'd0, e_cs ? t_wd : 32'h0, e_rsp});
            if (|e_rsp) check("rand_rdata", rsp_rdata, t_wr ? 32'h0 : t_rd);
            if (|e_ready) begin
                for (int j = 0; j < 3; j++) if (e_ready[j]) t_idx = j;
                t_acc = c;
                ref_last = t_idx;
                t_wr = req_write[t_idx];
                t_addr = req_addr[t_idx*2 +: 2];
                t_wd = req_wdata[t_idx*32 +: 32];
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
